// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control encodings for the pipelined RV32I control unit
//
// Purpose: ALU / immediate / result / access-size encodings, RV32I opcode
// constants, the E-stage control word and the bubble constant used by
// control_decoder and control_unit_pipe.
// Ports: none (package).
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1010,
    ALU_SRA   = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Everything the E stage carries apart from the register indices.
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        jump;
    logic        branch;
    logic [2:0]  branch_type;
    alu_op_e     alu_control;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        illegal;
  } ctrl_word_t;

  // A bubble is simply the all-zero word: no enables, not illegal.
  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - combinational RV32I decode of the F/D instruction
//
// Purpose: maps opcode/funct3/funct7 to the control word, the immediate
// format and the rs1/rs2 usage flags consumed by the load-use detector.
// Ports:
//   i_opcode, i_funct3, i_funct7 : instruction fields from the F/D register
//   o_ctrl                       : E-stage control word (zero + illegal if undecodable)
//   o_imm_src                    : immediate format for the D-stage extender
//   o_rs1_used, o_rs2_used       : source registers actually read
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output ctrl_word_t o_ctrl,
  output imm_src_e   o_imm_src,
  output logic       o_rs1_used,
  output logic       o_rs2_used
);

  logic w_f7_zero;
  logic w_f7_alt;
  logic w_bad;

  assign w_f7_zero = (i_funct7 == 7'b0000000);
  assign w_f7_alt  = (i_funct7 == 7'b0100000);

  always_comb begin
    o_ctrl     = CTRL_BUBBLE;
    o_imm_src  = IMM_I;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    w_bad      = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        o_ctrl.reg_write   = 1'b1;
        o_rs1_used         = 1'b1;
        o_rs2_used         = 1'b1;
        // funct7[5] lands on bit 3 of the ALU code: 000->SUB, 101->SRA.
        o_ctrl.alu_control = alu_op_e'({i_funct7[5], i_funct3});
        w_bad = !(w_f7_zero || (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.alu_src_b   = 1'b1;
        o_rs1_used         = 1'b1;
        // Only SRAI looks at funct7[5]; for ADDI/SUB-like codes it is immediate data.
        o_ctrl.alu_control = alu_op_e'({(i_funct3 == 3'b101) && i_funct7[5], i_funct3});
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
          w_bad = !(w_f7_zero || w_f7_alt);
        end
      end
      OPC_LOAD: begin
        o_ctrl.reg_write    = 1'b1;
        o_ctrl.result_src   = RES_MEM;
        o_ctrl.alu_src_b    = 1'b1;
        o_rs1_used          = 1'b1;
        o_ctrl.mem_size     = mem_size_e'(i_funct3[1:0]);
        o_ctrl.mem_unsigned = i_funct3[2];
        w_bad = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
      end
      OPC_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src_b = 1'b1;
        o_imm_src        = IMM_S;
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
        o_ctrl.mem_size  = mem_size_e'(i_funct3[1:0]);
        w_bad = i_funct3[2] || (i_funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        o_ctrl.branch      = 1'b1;
        o_ctrl.branch_type = i_funct3;
        o_ctrl.alu_control = ALU_SUB;
        o_imm_src          = IMM_B;
        o_rs1_used         = 1'b1;
        o_rs2_used         = 1'b1;
        w_bad = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
      end
      OPC_LUI: begin
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.alu_control = ALU_PASSB;
        o_ctrl.alu_src_b   = 1'b1;
        o_imm_src          = IMM_U;
      end
      OPC_AUIPC: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 1'b1;
        o_imm_src        = IMM_U;
      end
      OPC_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.jump       = 1'b1;
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = 1'b1;
        o_imm_src         = IMM_J;
      end
      OPC_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.jump       = 1'b1;
        o_ctrl.alu_src_b  = 1'b1;
        o_rs1_used        = 1'b1;
        w_bad = (i_funct3 != 3'b000);
      end
      default: w_bad = 1'b1;
    endcase
    // Undecodable: zero everything so nothing downstream acts, and drop the
    // usage flags so a garbage word never stalls the pipe.
    if (w_bad) begin
      o_ctrl         = CTRL_BUBBLE;
      o_ctrl.illegal = 1'b1;
      o_imm_src      = IMM_I;
      o_rs1_used     = 1'b0;
      o_rs2_used     = 1'b0;
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// rtl/control_unit_pipe.sv - pipelined RV32I control unit with load-use hazard detection
//
// Purpose: decodes InstrD in D, carries the control word through E/M/W with
// bubble insertion, and drives stall/flush for the PC and F/D registers.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   InstrD, PCSrcE            : F/D instruction, taken branch/jump from E
//   ImmSrcD, Rs1D, Rs2D       : combinational decode outputs
//   StallF, StallD, FlushD    : hazard controls
//   *E / *M / *W              : per-stage control and register indices
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,   // must be at least 4; upper bits read as zero
  parameter int HAZARD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  PCSrcE,
  output logic [2:0]            ImmSrcD,
  output logic [REG_ADDR_W-1:0] Rs1D,
  output logic [REG_ADDR_W-1:0] Rs2D,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  RegWriteE,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcE,
  output logic [1:0]            ResultSrcM,
  output logic [1:0]            ResultSrcW,
  output logic                  MemWriteE,
  output logic                  MemWriteM,
  output logic [1:0]            MemSizeE,
  output logic [1:0]            MemSizeM,
  output logic                  MemUnsignedE,
  output logic                  MemUnsignedM,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [2:0]            BranchTypeE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcBE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic                  IllegalE
);

  ctrl_word_t            w_ctrl_d;
  imm_src_e              w_imm_src_d;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic                  w_lw_stall;
  logic                  w_flush_e;
  logic [REG_ADDR_W-1:0] w_rd_d;

  ctrl_word_t            r_ctrl_e;
  logic [REG_ADDR_W-1:0] r_rd_e, r_rs1_e, r_rs2_e;
  logic                  r_reg_write_m, r_mem_write_m, r_mem_unsigned_m;
  logic [1:0]            r_result_src_m, r_mem_size_m;
  logic [REG_ADDR_W-1:0] r_rd_m;
  logic                  r_reg_write_w;
  logic [1:0]            r_result_src_w;
  logic [REG_ADDR_W-1:0] r_rd_w;

  control_decoder u_decoder (
    .i_opcode   (InstrD[6:0]),
    .i_funct3   (InstrD[14:12]),
    .i_funct7   (InstrD[31:25]),
    .o_ctrl     (w_ctrl_d),
    .o_imm_src  (w_imm_src_d),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign ImmSrcD = w_imm_src_d;
  assign Rs1D    = REG_ADDR_W'(InstrD[19:15]);
  assign Rs2D    = REG_ADDR_W'(InstrD[24:20]);
  assign w_rd_d  = REG_ADDR_W'(InstrD[11:7]);

  // A load in E whose destination is read by the instruction in D.
  // Only sources the D instruction really reads count, so an immediate
  // field that happens to alias RdE does not stall.
  assign w_lw_stall = (HAZARD_EN != 0) && (r_ctrl_e.result_src == RES_MEM) && (r_rd_e != '0) &&
                      (((Rs1D == r_rd_e) && w_rs1_used) || ((Rs2D == r_rd_e) && w_rs2_used));

  // A redirect makes the stalled instruction dead anyway, so it wins.
  assign StallF    = w_lw_stall & ~PCSrcE;
  assign StallD    = w_lw_stall & ~PCSrcE;
  assign FlushD    = PCSrcE;
  assign w_flush_e = w_lw_stall | PCSrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_e         <= CTRL_BUBBLE;
      r_rd_e           <= '0;
      r_rs1_e          <= '0;
      r_rs2_e          <= '0;
      r_reg_write_m    <= 1'b0;
      r_result_src_m   <= 2'b00;
      r_mem_write_m    <= 1'b0;
      r_mem_size_m     <= 2'b00;
      r_mem_unsigned_m <= 1'b0;
      r_rd_m           <= '0;
      r_reg_write_w    <= 1'b0;
      r_result_src_w   <= 2'b00;
      r_rd_w           <= '0;
    end else begin
      if (w_flush_e) begin
        r_ctrl_e <= CTRL_BUBBLE;
        r_rd_e   <= '0;
        r_rs1_e  <= '0;
        r_rs2_e  <= '0;
      end else begin
        r_ctrl_e <= w_ctrl_d;
        r_rd_e   <= w_rd_d;
        r_rs1_e  <= Rs1D;
        r_rs2_e  <= Rs2D;
      end
      r_reg_write_m    <= r_ctrl_e.reg_write;
      r_result_src_m   <= r_ctrl_e.result_src;
      r_mem_write_m    <= r_ctrl_e.mem_write;
      r_mem_size_m     <= r_ctrl_e.mem_size;
      r_mem_unsigned_m <= r_ctrl_e.mem_unsigned;
      r_rd_m           <= r_rd_e;
      r_reg_write_w    <= r_reg_write_m;
      r_result_src_w   <= r_result_src_m;
      r_rd_w           <= r_rd_m;
    end
  end

  assign RegWriteE    = r_ctrl_e.reg_write;
  assign ResultSrcE   = r_ctrl_e.result_src;
  assign MemWriteE    = r_ctrl_e.mem_write;
  assign MemSizeE     = r_ctrl_e.mem_size;
  assign MemUnsignedE = r_ctrl_e.mem_unsigned;
  assign JumpE        = r_ctrl_e.jump;
  assign BranchE      = r_ctrl_e.branch;
  assign BranchTypeE  = r_ctrl_e.branch_type;
  assign ALUControlE  = ALU_CTRL_W'(r_ctrl_e.alu_control);
  assign ALUSrcAE     = r_ctrl_e.alu_src_a;
  assign ALUSrcBE     = r_ctrl_e.alu_src_b;
  assign IllegalE     = r_ctrl_e.illegal;
  assign RdE          = r_rd_e;
  assign Rs1E         = r_rs1_e;
  assign Rs2E         = r_rs2_e;

  assign RegWriteM    = r_reg_write_m;
  assign ResultSrcM   = r_result_src_m;
  assign MemWriteM    = r_mem_write_m;
  assign MemSizeM     = r_mem_size_m;
  assign MemUnsignedM = r_mem_unsigned_m;
  assign RdM          = r_rd_m;

  assign RegWriteW    = r_reg_write_w;
  assign ResultSrcW   = r_result_src_w;
  assign RdW          = r_rd_w;

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb/tb_control_unit_pipe.sv - self-checking bench for control_unit_pipe
module tb_control_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic        PCSrcE;
    logic [2:0]  ImmSrcD;
    logic [4:0]  Rs1D, Rs2D;
    logic        StallF, StallD, FlushD;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE, ResultSrcM, ResultSrcW;
    logic        MemWriteE, MemWriteM;
    logic [1:0]  MemSizeE, MemSizeM;
    logic        MemUnsignedE, MemUnsignedM;
    logic        JumpE, BranchE;
    logic [2:0]  BranchTypeE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcAE, ALUSrcBE;
    logic [4:0]  RdE, RdM, RdW, Rs1E, Rs2E;
    logic        IllegalE;

    always #5 clk = ~clk;

    control_unit_pipe #(.REG_ADDR_W(5), .ALU_CTRL_W(4), .HAZARD_EN(1)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCSrcE(PCSrcE),
        .ImmSrcD(ImmSrcD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .MemSizeE(MemSizeE), .MemSizeM(MemSizeM),
        .MemUnsignedE(MemUnsignedE), .MemUnsignedM(MemUnsignedM),
        .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
        .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .IllegalE(IllegalE)
    );

    int total = 0;
    int bad   = 0;
    logic done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADD3    = 32'h002081B3;
    localparam logic [31:0] SUB0    = 32'h40208033;
    localparam logic [31:0] LW5     = 32'h0000A283;
    localparam logic [31:0] ADD6_5  = 32'h00228333;
    localparam logic [31:0] LW0     = 32'h0000A003;
    localparam logic [31:0] ADD6_0  = 32'h00200333;
    localparam logic [31:0] BEQ     = 32'h00208063;
    localparam logic [31:0] BGEU    = 32'h0020F063;
    localparam logic [31:0] LD011   = 32'h0000B283;
    localparam logic [31:0] OP7F    = 32'h0000007F;
    localparam logic [31:0] SH      = 32'h00209023;
    localparam logic [31:0] LHU     = 32'h0000D283;
    localparam logic [31:0] AUIPC   = 32'h00001297;
    localparam logic [31:0] SRAI    = 32'h40315293;
    localparam logic [31:0] SLLIBAD = 32'h02009293;
    localparam logic [31:0] LUI     = 32'h123452B7;
    localparam logic [31:0] JAL     = 32'h000000EF;
    localparam logic [31:0] JALR    = 32'h000280E7;
    localparam logic [31:0] SW5     = 32'h0050A023;
    localparam logic [31:0] ADDI_X1 = 32'h00508313;
    localparam logic [31:0] ADDI6_5 = 32'h00128313;

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic [1:0] msz;
        logic       mu;
        logic       j;
        logic       b;
        logic [2:0] bt;
        logic [3:0] alu;
        logic       sa;
        logic       sb;
        logic       ill;
        logic [2:0] imm;
        logic       u1;
        logic       u2;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        d = '0; ok = 1'b1;
        case (op)
            7'h33: begin
                d.rw = 1; d.u1 = 1; d.u2 = 1;
                if (f7 == 7'h00) d.alu = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd8;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd13;
                else ok = 0;
            end
            7'h13: begin
                d.rw = 1; d.sb = 1; d.u1 = 1; d.alu = {1'b0, f3};
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (f7 != 7'h00 && f7 != 7'h20) ok = 0;
                    else if (f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd13;
                end
            end
            7'h03: begin
                d.rw = 1; d.rs = 2'b01; d.sb = 1; d.u1 = 1;
                case (f3)
                    3'd0: d.msz = 2'd0;
                    3'd1: d.msz = 2'd1;
                    3'd2: d.msz = 2'd2;
                    3'd4: begin d.msz = 2'd0; d.mu = 1; end
                    3'd5: begin d.msz = 2'd1; d.mu = 1; end
                    default: ok = 0;
                endcase
            end
            7'h23: begin
                d.mw = 1; d.sb = 1; d.imm = 3'd1; d.u1 = 1; d.u2 = 1;
                if (f3 <= 3'd2) d.msz = f3[1:0]; else ok = 0;
            end
            7'h63: begin
                d.b = 1; d.bt = f3; d.alu = 4'd8; d.imm = 3'd2; d.u1 = 1; d.u2 = 1;
                if (f3 == 3'd2 || f3 == 3'd3) ok = 0;
            end
            7'h37: begin d.rw = 1; d.alu = 4'd10; d.sb = 1; d.imm = 3'd3; end
            7'h17: begin d.rw = 1; d.sa = 1; d.sb = 1; d.imm = 3'd3; end
            7'h6F: begin d.rw = 1; d.rs = 2'b10; d.j = 1; d.sa = 1; d.sb = 1; d.imm = 3'd4; end
            7'h67: begin
                d.rw = 1; d.rs = 2'b10; d.j = 1; d.sb = 1; d.u1 = 1;
                if (f3 != 3'd0) ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin d = '0; d.ill = 1; end
        return d;
    endfunction

    dec_t       mE;
    logic [4:0] mRdE, mRs1E, mRs2E;
    logic       mRwM, mMwM, mMuM;
    logic [1:0] mRsM, mMszM;
    logic [4:0] mRdM;
    logic       mRwW;
    logic [1:0] mRsW;
    logic [4:0] mRdW;

    function automatic logic exp_lw_stall();
        dec_t dd;
        dd = ref_decode(InstrD);
        return (mE.rs == 2'b01) && (mRdE != 5'd0) &&
               ((InstrD[19:15] == mRdE && dd.u1) || (InstrD[24:20] == mRdE && dd.u2));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mE = '0; mRdE = 0; mRs1E = 0; mRs2E = 0;
            mRwM = 0; mMwM = 0; mMuM = 0; mRsM = 0; mMszM = 0; mRdM = 0;
            mRwW = 0; mRsW = 0; mRdW = 0;
        end else begin
            logic fl;
            fl = exp_lw_stall() || PCSrcE;
            mRwW = mRwM; mRsW = mRsM; mRdW = mRdM;
            mRwM = mE.rw; mRsM = mE.rs; mMwM = mE.mw; mMszM = mE.msz; mMuM = mE.mu; mRdM = mRdE;
            if (fl) begin
                mE = '0; mRdE = 0; mRs1E = 0; mRs2E = 0;
            end else begin
                mE = ref_decode(InstrD);
                mRdE = InstrD[11:7]; mRs1E = InstrD[19:15]; mRs2E = InstrD[24:20];
            end
        end
    end

    always @(negedge clk) begin
        dec_t dd;
        logic st;
        dd = ref_decode(InstrD);
        st = exp_lw_stall() && !PCSrcE;
        chk("ImmSrcD", ImmSrcD, dd.imm);
        chk("Rs1D", Rs1D, InstrD[19:15]);
        chk("Rs2D", Rs2D, InstrD[24:20]);
        chk("StallF", StallF, st);
        chk("StallD", StallD, st);
        chk("FlushD", FlushD, PCSrcE);
        chk("RegWriteE", RegWriteE, mE.rw);
        chk("ResultSrcE", ResultSrcE, mE.rs);
        chk("MemWriteE", MemWriteE, mE.mw);
        chk("MemSizeE", MemSizeE, mE.msz);
        chk("MemUnsignedE", MemUnsignedE, mE.mu);
        chk("JumpE", JumpE, mE.j);
        chk("BranchE", BranchE, mE.b);
        chk("BranchTypeE", BranchTypeE, mE.bt);
        chk("ALUControlE", ALUControlE, mE.alu);
        chk("ALUSrcAE", ALUSrcAE, mE.sa);
        chk("ALUSrcBE", ALUSrcBE, mE.sb);
        chk("IllegalE", IllegalE, mE.ill);
        chk("RdE", RdE, mRdE);
        chk("Rs1E", Rs1E, mRs1E);
        chk("Rs2E", Rs2E, mRs2E);
        chk("RegWriteM", RegWriteM, mRwM);
        chk("ResultSrcM", ResultSrcM, mRsM);
        chk("MemWriteM", MemWriteM, mMwM);
        chk("MemSizeM", MemSizeM, mMszM);
        chk("MemUnsignedM", MemUnsignedM, mMuM);
        chk("RdM", RdM, mRdM);
        chk("RegWriteW", RegWriteW, mRwW);
        chk("ResultSrcW", ResultSrcW, mRsW);
        chk("RdW", RdW, mRdW);
    end

    task automatic cyc(input logic [31:0] ins, input logic pcs);
        @(posedge clk);
        #1;
        InstrD = ins;
        PCSrcE = pcs;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        if (!done) begin
            bad++;
            $display("FAIL timeout: stimulus did not complete t=%0t", $time);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        dec_t pin;
        rst = 1'b0; InstrD = 32'h0; PCSrcE = 1'b0;
        #2 rst = 1'b1;

        pin = ref_decode(SUB0);  chk("model_sub_alu", pin.alu, 4'b1000);
        pin = ref_decode(LHU);   chk("model_lhu_size", {pin.msz, pin.mu}, 3'b011);
        pin = ref_decode(OP7F);  chk("model_7f_ill", {pin.ill, pin.rw}, 2'b10);
        pin = ref_decode(SRAI);  chk("model_srai_alu", pin.alu, 4'b1101);

        repeat (2) @(negedge clk);
        chk("rst_RegWriteE", RegWriteE, 1'b0);
        chk("rst_IllegalE", IllegalE, 1'b0);
        chk("rst_StallD", StallD, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        cyc(SUB0, 0); cyc(NOP, 0);
        chk("lat_aluE", ALUControlE, 4'b1000);
        chk("lat_rwE", RegWriteE, 1'b1);
        cyc(NOP, 0);
        chk("lat_rwM", RegWriteM, 1'b1);
        cyc(NOP, 0);
        chk("lat_rwW", RegWriteW, 1'b1);
        chk("lat_rdW", RdW, 5'd0);

        cyc(ADD3, 0); cyc(ADD3, 0);
        chk("pre_rst_rwE", RegWriteE, 1'b1);
        chk("pre_rst_rwM", RegWriteM, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rwE", RegWriteE, 1'b0);
        chk("async_rst_rdE", RdE, 5'd0);
        chk("async_rst_rwM", RegWriteM, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        cyc(NOP, 0);
        chk("post_rst_rwE", RegWriteE, 1'b1);
        chk("post_rst_rdE", RdE, 5'd3);

        cyc(LW5, 0); cyc(ADD6_5, 0);
        chk("lu_stallF", StallF, 1'b1);
        chk("lu_stallD", StallD, 1'b1);
        chk("lu_resE", ResultSrcE, 2'b01);
        cyc(ADD6_5, 0);
        chk("lu_bubble_rwE", RegWriteE, 1'b0);
        chk("lu_release", StallD, 1'b0);
        cyc(NOP, 0);
        chk("lu_late_rdE", RdE, 5'd6);
        chk("lu_late_rs1E", Rs1E, 5'd5);

        cyc(LW0, 0); cyc(ADD6_0, 0);
        chk("x0_nostall", StallD, 1'b0);
        cyc(NOP, 0);
        chk("x0_rdE", RdE, 5'd6);

        cyc(LW5, 0); cyc(ADD6_5, 1);
        chk("prio_stall", StallD, 1'b0);
        chk("prio_flushD", FlushD, 1'b1);
        cyc(NOP, 0);
        chk("prio_bubble", RegWriteE, 1'b0);
        chk("prio_resM", ResultSrcM, 2'b01);

        cyc(BEQ, 0); cyc(ADD3, 1);
        chk("br_branchE", BranchE, 1'b1);
        chk("br_flushD", FlushD, 1'b1);
        cyc(NOP, 0);
        chk("br_bubble_b", BranchE, 1'b0);
        chk("br_bubble_rw", RegWriteE, 1'b0);

        cyc(LD011, 0); cyc(NOP, 0);
        chk("ill_ld_illE", IllegalE, 1'b1);
        chk("ill_ld_rwE", RegWriteE, 1'b0);
        cyc(OP7F, 0); cyc(NOP, 0);
        chk("ill_7f_illE", IllegalE, 1'b1);

        cyc(SH, 0); cyc(LHU, 0);
        chk("sh_sizeE", MemSizeE, 2'b01);
        chk("sh_mwE", MemWriteE, 1'b1);
        cyc(AUIPC, 0);
        chk("lhu_sizeE", MemSizeE, 2'b01);
        chk("lhu_unsE", MemUnsignedE, 1'b1);
        chk("auipc_immD", ImmSrcD, 3'b011);
        cyc(SRAI, 0);
        chk("auipc_srcA", ALUSrcAE, 1'b1);
        cyc(BGEU, 0);
        chk("srai_alu", ALUControlE, 4'b1101);
        cyc(SLLIBAD, 0);
        chk("bgeu_type", BranchTypeE, 3'b111);
        cyc(LUI, 0);
        chk("slli_bad_ill", IllegalE, 1'b1);
        cyc(JAL, 0);
        chk("lui_alu", ALUControlE, 4'b1010);
        cyc(JALR, 0);
        chk("jal_res", ResultSrcE, 2'b10);
        chk("jal_srcA", ALUSrcAE, 1'b1);
        cyc(NOP, 0);
        chk("jalr_jump", JumpE, 1'b1);
        chk("jalr_srcA", ALUSrcAE, 1'b0);

        cyc(LW5, 0); cyc(SW5, 0);
        chk("sw_stall", StallD, 1'b1);
        cyc(SW5, 0); cyc(NOP, 0);
        chk("sw_rs2E", Rs2E, 5'd5);
        cyc(LW5, 0); cyc(ADDI_X1, 0);
        chk("imm_alias_nostall", StallD, 1'b0);
        cyc(LW5, 0); cyc(ADDI6_5, 0);
        chk("addi_stall", StallF, 1'b1);
        cyc(ADDI6_5, 0);
        repeat (3) cyc(NOP, 0);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Parametrised successor to the single-cycle decode control unit. It decodes the full RV32I integer subset in the Decode stage and carries the control word through the E, M and W pipeline registers with bubble insertion. It also contains the load-use hazard detector, generating the stall and flush signals for the fetch/decode registers. It sits between the F/D instruction register and the datapath stages.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- ALU_CTRL_W, 4: ALU control width; must be ≥4.
- HAZARD_EN, 1: 1 enables the load-use detector; 0 ties StallF/StallD low.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- InstrD  in  32  instruction held in the F/D register.
- PCSrcE  in  1  taken branch or jump resolved in E.
- ImmSrcD  out  3  immediate format, combinational from InstrD.
- Rs1D, Rs2D  out  REG_ADDR_W  source indices, combinational.
- StallF, StallD, FlushD  out  1  hazard controls to the PC register and the F/D register.
- RegWriteE/M/W  out  1  per-stage register-write enable.
- ResultSrcE/M/W  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
- MemWriteE/M  out  1  store enable.
- MemSizeE/M  out  2  access size: 00 byte, 01 half, 10 word.
- MemUnsignedE/M  out  1  zero-extend load.
- JumpE, BranchE  out  1  jump / branch in E.
- BranchTypeE  out  3  funct3 of the branch.
- ALUControlE  out  ALU_CTRL_W  ALU operation.
- ALUSrcAE  out  1  ALU operand A: 1 selects PC (AUIPC, JAL).
- ALUSrcBE  out  1  ALU operand B: 1 selects the immediate.
- RdE/M/W, Rs1E, Rs2E  out  REG_ADDR_W  register indices per stage.
- IllegalE  out  1  the E-stage instruction was undecodable.

## Operation
- **ALU codes:** 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA, 1010 PASSB.
- **OP (0110011):** funct7[5] selects SUB and SRA.
- **OP-IMM (0010011):**
  - funct7[5] is honoured only for SRAI.
  - SLLI/SRLI/SRAI with imm[11:5] other than 0000000 or 0100000 are illegal.
- **ImmSrc codes:** 000 I, 001 S, 010 B, 011 U, 100 J.
- **Opcode mapping:**
  - LUI: ALU PASSB with U immediate.
  - AUIPC: ALU ADD with ALUSrcA=1.
  - JAL: ALUSrcA=1, J immediate.
  - JALR: rs1 plus I immediate.
  - All jumps: ResultSrc=10, RegWrite=1.
- **Branches:** all six funct3 values (000, 001, 100, 101, 110, 111) assert Branch with ALU SUB. funct3 010 and 011 are illegal.
- **Loads:** LB, LH, LW, LBU, LHU set MemSize and MemUnsigned; all other funct3 values are illegal.
- **Stores:** SB, SH, SW; all other funct3 values are illegal.
- **Illegal instructions:** any undecoded opcode or funct combination produces the all-zero control word with Illegal=1.
- **Source usage flags:** decoder-internal; not registered or output.
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
- **Load-use hazard:** lwStall = HAZARD_EN & (ResultSrcE==01) & RdE≠0 & ((Rs1D==RdE & rs1 used) | (Rs2D==RdE & rs2 used)).
- **Hazard outputs:**
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - flushE = lwStall | PCSrcE.
- **Bubble:** flushE loads a bubble into E at the next edge. A bubble has every enable 0 (RegWrite, MemWrite, Jump, Branch, Illegal); the other fields are 0.
- **M/W registers:** advance every cycle with no stall input. M takes E's fields; W takes M's RegWrite, ResultSrc and Rd.

## Timing
- **Decode to E:** decode is combinational in D. The E word is valid one cycle after InstrD; M follows after 2 cycles and W after 3.
- **Reset:** every registered output clears to 0 immediately on rst, without waiting for a clock edge.
  - Combinational outputs follow InstrD=0, which is illegal and gives zero controls.
  - StallF, StallD, FlushD and flushE are 0 while E is zero.
- **Reset mid-stream:** rst asserted mid-stream discards all in-flight control. The first instruction after release takes the normal 1/2/3-cycle latency.
- **Simultaneous PCSrcE and lwStall:** cannot arise legally. If both are asserted, PCSrcE wins: no stall, both D and E are flushed.
- **Load-use stall:** lasts exactly one cycle. The next cycle holds a bubble in E, so lwStall deasserts.
- **x0:** RdE = x0 never causes a stall.

## Structure
- **Package `ctrl_pkg`:** holds
  - the ALU, ImmSrc, ResultSrc and MemSize enums;
  - the opcode constants;
  - the packed struct `ctrl_word_t`, covering every E-stage field except the register indices;
  - the constant `CTRL_BUBBLE`.
- **Sub-module `control_decoder`:** purely combinational. It maps InstrD to `ctrl_word_t` plus the rs1/rs2 usage flags, and is instantiated once.
- **Top level:** the pipeline registers and the hazard logic.

## Test plan
- **Reset:** rst pulse while issuing ADD → all E/M/W outputs 0 immediately. The ADD issued after release gives RegWriteE=1 one cycle later.
- **Latency:** InstrD=0x40208033 (sub x0,x1,x2) → ALUControlE=1000 at cycle 1, RegWriteM at cycle 2, RegWriteW=1 with RdW=0 at cycle 3.
- **Load-use:** lw x5,0(x1) then add x6,x5,x2 → one cycle of StallF=StallD=1, E holds a bubble, the add reaches E one cycle late. The same sequence with rd=x0 → no stall.
- **Branch flush:** PCSrcE=1 → FlushD=1, E shows a bubble next cycle, M keeps the branch word.
- **Illegal decode:** InstrD with funct3 011 on LOAD → IllegalE=1 with RegWriteE=0. Unknown opcode 0x7F → IllegalE=1.
- **Field decode:**
  - SH, LHU: MemSize 01, MemUnsigned 1 for LHU.
  - AUIPC: ALUSrcAE=1.
  - SRAI: ALU 1101.
  - BGEU: BranchTypeE=111.
